// File: rtl/drp_reconf_ctrl_pkg.sv
// Shared definitions for the PLL DRP reconfiguration controller:
// FSM state encoding and the two register configuration sets.
package drp_reconf_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_PLL,
    READ,
    WAIT_R,
    MODIFY,
    WRITE,
    WAIT_W,
    NEXT,
    RELEASE,
    WAIT_LOCK,
    DONE
  } state_e;

  localparam int ROM_IDX_W = 3;

  // Bits kept from the value read back from the PLL for each register kind.
  localparam logic [15:0] MASK_CLKREG1  = 16'h1000;
  localparam logic [15:0] MASK_CLKREG2  = 16'hFC00;
  localparam logic [15:0] MASK_DIVREG   = 16'hC000;
  localparam logic [15:0] MASK_POWERREG = 16'h0000;

  // Register order shared by both sets; element 0 is written first.
  localparam logic [7:0][6:0] REG_ADDR = {
    7'h28, 7'h16, 7'h15, 7'h14, 7'h0B, 7'h0A, 7'h09, 7'h08
  };

  localparam logic [7:0][15:0] REG_MASK = {
    MASK_POWERREG, MASK_DIVREG, MASK_CLKREG2, MASK_CLKREG1,
    MASK_CLKREG2,  MASK_CLKREG1, MASK_CLKREG2, MASK_CLKREG1
  };

  // Set 0 runs CLKOUT0 at divide 4, set 1 at divide 8. Data bits under a
  // mask bit are always zero so the OR merge never corrupts kept bits.
  localparam logic [1:0][7:0][15:0] REG_DATA = {
    {16'hFFFF, 16'h1082, 16'h0000, 16'h0186, 16'h0000, 16'h0082, 16'h0000, 16'h0104},
    {16'hFFFF, 16'h1041, 16'h0000, 16'h0145, 16'h0000, 16'h0041, 16'h0000, 16'h0082}
  };

  // Read-modify-write merge: keep masked bits of the readback, insert new field values.
  function automatic logic [15:0] merge_field(input logic [15:0] rd,
                                              input logic [15:0] mask,
                                              input logic [15:0] data);
    return (rd & mask) | data;
  endfunction

endpackage

// File: rtl/drp_reconf_ctrl_rom.sv
// Combinational configuration table, indexed by {set, index}.
module reconf_rom
  import drp_reconf_ctrl_pkg::*;
(
  input  logic                 set,
  input  logic [ROM_IDX_W-1:0] idx,
  output logic [6:0]           addr,
  output logic [15:0]          mask,
  output logic [15:0]          data
);

  // Pure table lookup; address and mask are common to both sets.
  always_comb begin
    addr = REG_ADDR[idx];
    mask = REG_MASK[idx];
    data = REG_DATA[set][idx];
  end

endmodule

// File: rtl/drp_reconf_ctrl.sv
// PLL dynamic reconfiguration controller: holds the PLL in reset, performs a
// read-modify-write of every table entry over DRP, then waits for lock.
module drp_reconf_ctrl
  import drp_reconf_ctrl_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int TIMEOUT = 255
)
(
  input  logic        DCLK,
  input  logic        RST,
  input  logic        SSTEP,
  input  logic        SSTATE,
  input  logic        LOCKED,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  output logic        PLL_RST,
  output logic        SRDY,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [ROM_IDX_W-1:0] IDX_LAST  = ROM_IDX_W'(ENTRIES - 1);
  localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT - 1);

  state_e                 state, next_state;
  logic                   set_sel;
  logic [ROM_IDX_W-1:0]   idx, idx_nxt;
  logic [7:0]             wait_cnt;
  logic                   in_wait;
  logic                   wait_expired;
  logic                   drdy_seen;
  logic                   timeout_hit;
  logic [15:0]            rd_data;
  logic [6:0]             rom_addr;
  logic [15:0]            rom_mask;
  logic [15:0]            rom_data;

  // The table is addressed with the index the FSM is about to use, so the
  // DRP bus registers can load the correct entry on entry to READ/WRITE.
  reconf_rom u_rom (
    .set  (set_sel),
    .idx  (idx_nxt),
    .addr (rom_addr),
    .mask (rom_mask),
    .data (rom_data)
  );

  assign in_wait      = (state == RST_PLL) || (state == WAIT_R) ||
                        (state == WAIT_W)  || (state == WAIT_LOCK);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  // First cycle after a DEN is skipped: DRDY may still reflect the previous access.
  assign drdy_seen    = DRDY && (wait_cnt != 8'd0);

  // Next-state, index and timeout decode.
  always_comb begin
    next_state  = state;
    idx_nxt     = idx;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (SSTEP) begin
          next_state = RST_PLL;
          idx_nxt    = '0;
        end
      end
      RST_PLL: begin
        if (DRDY) begin
          next_state = READ;
        end else if (wait_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      READ:   next_state = WAIT_R;
      WAIT_R: begin
        if (drdy_seen) begin
          next_state = MODIFY;
        end else if (wait_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      MODIFY: next_state = WRITE;
      WRITE:  next_state = WAIT_W;
      WAIT_W: begin
        if (drdy_seen) begin
          next_state = NEXT;
        end else if (wait_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      NEXT: begin
        if (idx == IDX_LAST) begin
          next_state = RELEASE;
        end else begin
          idx_nxt    = idx + 1'b1;
          next_state = READ;
        end
      end
      RELEASE: next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (LOCKED) begin
          next_state = DONE;
        end else if (wait_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge DCLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Sequence control: set select, entry index, wait counter and sticky error.
  always_ff @(posedge DCLK) begin
    if (RST) begin
      set_sel  <= 1'b0;
      idx      <= '0;
      wait_cnt <= 8'd0;
      ERR      <= 1'b0;
    end else begin
      idx <= idx_nxt;
      if (state == IDLE && SSTEP) begin
        set_sel <= SSTATE;
        ERR     <= 1'b0;
      end
      if (timeout_hit) ERR <= 1'b1;
      if (next_state != state) wait_cnt <= 8'd0;
      else if (in_wait)        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // DRP bus registers: address/direction load on entry to an access cycle,
  // write data loads in MODIFY, and all of them hold otherwise.
  always_ff @(posedge DCLK) begin
    if (RST) begin
      DADDR <= 7'd0;
      DWE   <= 1'b0;
      DI    <= 16'd0;
    end else begin
      if (next_state == READ || next_state == WRITE) begin
        DADDR <= rom_addr;
        DWE   <= (next_state == WRITE);
      end
      if (state == MODIFY) DI <= merge_field(rd_data, rom_mask, rom_data);
    end
  end

  // Readback capture on the completing DRDY.
  always_ff @(posedge DCLK) begin
    if (state == WAIT_R && drdy_seen) rd_data <= DO;
  end

  assign DEN     = (state == READ) || (state == WRITE);
  assign PLL_RST = (state == RST_PLL) || (state == READ)  || (state == WAIT_R) ||
                   (state == MODIFY)  || (state == WRITE) || (state == WAIT_W) ||
                   (state == NEXT);
  assign SRDY    = (state == DONE);
  assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_drp_reconf_ctrl.sv
// Bench for drp_reconf_ctrl: behavioural PLL/DRP responder plus a reference
// of the expected write sequence computed from the register table rules.
module tb_drp_reconf_ctrl;

  localparam int TO = 255;

  logic        DCLK, RST, SSTEP, SSTATE, LOCKED, DRDY;
  logic [15:0] DO;
  logic [6:0]  DADDR;
  logic        DEN, DWE, PLL_RST, SRDY, BUSY, ERR;
  logic [15:0] DI;

  drp_reconf_ctrl #(.ENTRIES(8), .TIMEOUT(TO)) dut (
    .DCLK(DCLK), .RST(RST), .SSTEP(SSTEP), .SSTATE(SSTATE), .LOCKED(LOCKED),
    .DO(DO), .DRDY(DRDY), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
    .PLL_RST(PLL_RST), .SRDY(SRDY), .BUSY(BUSY), .ERR(ERR)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  // Reference register table.
  localparam logic [6:0]  B_ADDR  [8] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h16, 7'h28};
  localparam logic [15:0] B_DATA0 [8] = '{16'h0082, 16'h0000, 16'h0041, 16'h0000,
                                          16'h0145, 16'h0000, 16'h1041, 16'hFFFF};
  localparam logic [15:0] B_DATA1 [8] = '{16'h0104, 16'h0000, 16'h0082, 16'h0000,
                                          16'h0186, 16'h0000, 16'h1082, 16'hFFFF};

  function automatic logic [15:0] b_mask(input logic [6:0] a);
    case (a)
      7'h08, 7'h0A, 7'h14: return 16'h1000;
      7'h09, 7'h0B, 7'h15: return 16'hFC00;
      7'h16:               return 16'hC000;
      default:             return 16'h0000;
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // PLL model state and observation log.
  logic [15:0] mem  [128];
  logic [15:0] mem0 [128];
  int  cyc = 0, busy_cnt = 0, lock_wait = 0;
  int  den_cnt, srdy_cnt, b2b, nopll, hold_viol, err_cyc, pll_fall_cyc;
  int  stall_after = 0;
  bit  stall = 0, lock_never = 0;
  int  den_cyc[$];
  logic [6:0]  rd_q[$], wr_a[$];
  logic [15:0] wr_d[$];
  logic        prev_den = 0, prev_err = 0, prev_pll = 0, prev_rst = 1;
  logic [23:0] prev_bus = '0;
  logic        err_at_start;

  initial begin
    DRDY = 1'b1; DO = 16'h0; LOCKED = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    forever begin
      @(negedge DCLK);
      cyc++;
      if (DEN) begin
        den_cnt++;
        den_cyc.push_back(cyc);
        if (prev_den) b2b++;
        if (!PLL_RST) nopll++;
        if (DWE) begin
          wr_a.push_back(DADDR);
          wr_d.push_back(DI);
          mem[DADDR] = DI;
        end else begin
          rd_q.push_back(DADDR);
          DO = mem[DADDR];
        end
        busy_cnt = $urandom_range(1, 4);
        if (den_cnt == stall_after) stall = 1;
      end
      if (!DEN && !RST && !prev_rst && ({DWE, DADDR, DI} != prev_bus)) hold_viol++;
      prev_bus = {DWE, DADDR, DI};
      prev_rst = RST;
      prev_den = DEN;
      if (SRDY) srdy_cnt++;
      if (ERR && !prev_err) err_cyc = cyc;
      prev_err = ERR;
      if (!PLL_RST && prev_pll) pll_fall_cyc = cyc;
      prev_pll = PLL_RST;
      if (RST) busy_cnt = 0;
      if (busy_cnt > 0) begin
        DRDY = 1'b0;
        busy_cnt--;
      end else begin
        DRDY = !stall;
      end
      if (PLL_RST) begin
        LOCKED    = 1'b0;
        lock_wait = $urandom_range(1, 8);
      end else if (!LOCKED && !lock_never) begin
        if (lock_wait > 0) lock_wait--;
        else               LOCKED = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge DCLK);
    #1;
  endtask

  task automatic clear_log();
    den_cnt = 0; srdy_cnt = 0; b2b = 0; nopll = 0; hold_viol = 0;
    err_cyc = -1; pll_fall_cyc = -1;
    den_cyc.delete(); rd_q.delete(); wr_a.delete(); wr_d.delete();
  endtask

  task automatic prep_mem(input bit force8, input logic [15:0] v8);
    for (int i = 0; i < 8; i++) mem[B_ADDR[i]] = 16'($urandom);
    if (force8) mem[7'h08] = v8;
    mem0 = mem;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_den"},  32'(DEN), 0);
    check({pfx, "_dwe"},  32'(DWE), 0);
    check({pfx, "_daddr"}, 32'(DADDR), 0);
    check({pfx, "_di"},   32'(DI), 0);
    check({pfx, "_pllrst"}, 32'(PLL_RST), 0);
    check({pfx, "_srdy"}, 32'(SRDY), 0);
    check({pfx, "_busy"}, 32'(BUSY), 0);
    check({pfx, "_err"},  32'(ERR), 0);
  endtask

  // mode 0: plain run, 1: SSTEP pulsed while busy, 2: stop in WAIT_W with RST held
  task automatic run_seq(input logic set, input int mode, output logic done);
    clear_log();
    SSTATE = set;
    SSTEP  = 1'b1;
    tick();
    SSTEP  = 1'b0;
    SSTATE = ~set;
    err_at_start = ERR;
    done = 1'b0;
    if (mode == 2) begin
      for (int n = 0; n < 500 && den_cnt < 2; n++) tick();
      tick();
      RST = 1'b1;
      tick();
      done = 1'b1;
    end else begin
      for (int n = 0; n < 2000; n++) begin
        SSTEP = 1'b0;
        if (!BUSY) begin
          done = 1'b1;
          break;
        end
        if (mode == 1) begin
          SSTEP  = ($urandom_range(0, 3) == 0);
          SSTATE = 1'($urandom);
        end
        tick();
      end
      SSTEP = 1'b0;
    end
    check("seq_terminates", 32'(done), 1);
  endtask

  task automatic check_writes(input logic set, input string pfx);
    logic [6:0]  a;
    logic [15:0] exp_di;
    check({pfx, "_den_count"}, 32'(den_cnt), 16);
    check({pfx, "_srdy_count"}, 32'(srdy_cnt), 1);
    for (int i = 0; i < 8; i++) begin
      a      = B_ADDR[i];
      exp_di = (mem0[a] & b_mask(a)) | (set ? B_DATA1[i] : B_DATA0[i]);
      check($sformatf("%s_rd_addr%0d", pfx, i), (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF_FFFF, 32'(a));
      check($sformatf("%s_wr_addr%0d", pfx, i), (i < wr_a.size()) ? 32'(wr_a[i]) : 32'hFFFF_FFFF, 32'(a));
      check($sformatf("%s_wr_data%0d", pfx, i), (i < wr_d.size()) ? 32'(wr_d[i]) : 32'hFFFF_FFFF, 32'(exp_di));
    end
    check({pfx, "_den_b2b"}, 32'(b2b), 0);
    check({pfx, "_den_outside_pllrst"}, 32'(nopll), 0);
    check({pfx, "_bus_hold"}, 32'(hold_viol), 0);
    check({pfx, "_err"}, 32'(ERR), 0);
    check({pfx, "_pllrst_end"}, 32'(PLL_RST), 0);
  endtask

  logic done;
  logic rset;

  initial begin
    RST = 1'b1; SSTEP = 1'b0; SSTATE = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    RST = 1'b0;
    tick();

    // Set 0, readback 0xF3C7 at 0x08.
    prep_mem(1, 16'hF3C7);
    run_seq(1'b0, 0, done);
    check("s0_first_addr", (wr_a.size() > 0) ? 32'(wr_a[0]) : 32'hFFFF_FFFF, 32'h08);
    check("s0_first_di",   (wr_d.size() > 0) ? 32'(wr_d[0]) : 32'hFFFF_FFFF, 32'h1082);
    check_writes(1'b0, "s0");
    repeat (3) tick();

    // Set 1, readback 0x0000 at 0x08.
    prep_mem(1, 16'h0000);
    run_seq(1'b1, 0, done);
    check("s1_first_di", (wr_d.size() > 0) ? 32'(wr_d[0]) : 32'hFFFF_FFFF, 32'h0104);
    check_writes(1'b1, "s1");
    repeat (3) tick();

    // Random sets and readback contents.
    for (int r = 0; r < 3; r++) begin
      rset = 1'($urandom);
      prep_mem(0, 16'h0);
      run_seq(rset, 0, done);
      check_writes(rset, $sformatf("rnd%0d", r));
      repeat ($urandom_range(1, 5)) tick();
    end

    // DRDY stuck low after the third DEN.
    prep_mem(0, 16'h0);
    stall_after = 3;
    run_seq(1'b0, 0, done);
    check("stall_err", 32'(ERR), 1);
    check("stall_busy", 32'(BUSY), 0);
    check("stall_pllrst", 32'(PLL_RST), 0);
    check("stall_srdy_count", 32'(srdy_cnt), 0);
    check("stall_den_count", 32'(den_cnt), 3);
    check("stall_wait_cycles", (den_cyc.size() >= 3) ? 32'(err_cyc - den_cyc[2]) : 32'hFFFF_FFFF, 32'(TO + 1));
    stall_after = 0;
    stall = 0;
    repeat (6) tick();
    prep_mem(0, 16'h0);
    run_seq(1'b1, 0, done);
    check("restart_err_cleared", 32'(err_at_start), 0);
    check_writes(1'b1, "restart");
    repeat (3) tick();

    // SSTEP pulses while busy are ignored.
    prep_mem(0, 16'h0);
    run_seq(1'b0, 1, done);
    check_writes(1'b0, "nostep");
    repeat (20) tick();
    check("nostep_idle_busy", 32'(BUSY), 0);
    check("nostep_srdy_total", 32'(srdy_cnt), 1);
    check("nostep_den_total", 32'(den_cnt), 16);

    // Reset during WAIT_W.
    prep_mem(0, 16'h0);
    run_seq(1'b1, 2, done);
    check_quiet("midrst");
    RST = 1'b0;
    repeat (6) tick();
    check("midrst_stays_idle", 32'(BUSY), 0);
    prep_mem(0, 16'h0);
    run_seq(1'b0, 0, done);
    check_writes(1'b0, "postrst");
    repeat (3) tick();

    // PLL never locks.
    lock_never = 1;
    prep_mem(0, 16'h0);
    run_seq(1'b1, 0, done);
    check("nolock_err", 32'(ERR), 1);
    check("nolock_busy", 32'(BUSY), 0);
    check("nolock_srdy_count", 32'(srdy_cnt), 0);
    check("nolock_den_count", 32'(den_cnt), 16);
    check("nolock_wait_cycles", 32'(err_cyc - pll_fall_cyc), 32'(TO + 1));
    lock_never = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drp_reconf_ctrl.md
DRP_RECONF_CTRL -- requirements
Module: drp_reconf_ctrl

Interface
REQ-001 Parameter ENTRIES, default 8, meaning: number of DRP register entries per configuration set.
REQ-002 Parameter TIMEOUT, default 255, meaning: maximum cycles spent in any wait state before error.
REQ-003 DCLK  input  1  clock; all state changes occur on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 SSTEP  input  1  start request, sampled only in IDLE.
REQ-006 SSTATE  input  1  selects configuration set 0 or 1, latched with an accepted SSTEP.
REQ-007 LOCKED  input  1  PLL lock indication.
REQ-008 DO  input  16  DRP read data from the PLL.
REQ-009 DRDY  input  1  DRP ready; high when the PLL accepts a DEN, goes low for at least one cycle after a transaction, then returns high on completion.
REQ-010 DADDR  output  7  DRP address.
REQ-011 DEN  output  1  DRP enable, single-cycle pulse.
REQ-012 DWE  output  1  DRP write enable, valid only with DEN.
REQ-013 DI  output  16  DRP write data.
REQ-014 PLL_RST  output  1  drives PLL RST during reprogramming.
REQ-015 SRDY  output  1  one-cycle pulse on successful completion.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 ERR  output  1  sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, RST_PLL, READ, WAIT_R, MODIFY, WRITE, WAIT_W, NEXT, RELEASE, WAIT_LOCK and DONE.
REQ-019 IDLE with SSTEP=1 SHALL latch SSTATE, clear index and ERR, and enter RST_PLL; PLL_RST SHALL be 1 from the next cycle until RELEASE.
REQ-020 RST_PLL SHALL enter READ when DRDY=1.
REQ-021 READ SHALL drive DEN=1, DWE=0 and DADDR=table[set][index].addr for exactly one cycle, then enter WAIT_R.
REQ-022 WAIT_R SHALL ignore DRDY in its first cycle, then register DO on the first DRDY=1 and enter MODIFY.
REQ-023 MODIFY SHALL compute DI=(DO & mask) | data in one cycle; data bits under mask=1 SHALL be zero in the table.
REQ-024 WRITE SHALL drive DEN=1, DWE=1, DADDR and DI for exactly one cycle, then enter WAIT_W, which follows the same DRDY rule as WAIT_R.
REQ-025 NEXT SHALL enter RELEASE if index=ENTRIES-1; otherwise it SHALL increment index and enter READ.
REQ-026 RELEASE SHALL drive PLL_RST=0 and enter WAIT_LOCK; WAIT_LOCK SHALL enter DONE on LOCKED=1.
REQ-027 DONE SHALL pulse SRDY for one cycle and return to IDLE.
REQ-028 SSTEP outside IDLE SHALL be ignored, with no queuing.
REQ-029 An 8-bit wait counter SHALL clear on entry to RST_PLL, WAIT_R, WAIT_W and WAIT_LOCK; reaching TIMEOUT SHALL set ERR, drive PLL_RST=0 and enter IDLE without an SRDY pulse.
REQ-030 DEN SHALL never be high in two consecutive cycles; DADDR, DI and DWE SHALL hold their values outside DEN cycles.

Reset
REQ-031 RST=1 SHALL, on the next edge and from any state, set the state to IDLE and all outputs to 0, including PLL_RST, ERR and index; an in-flight DRP transaction SHALL be abandoned.

Structure
REQ-032 A shared package SHALL hold the state enum and the table constants (addr 7b, mask 16b, data 16b).
REQ-033 Both sets SHALL use this address order: 0x08, 0x09, 0x0A, 0x0B, 0x14, 0x15, 0x16, 0x28.
REQ-034 Masks SHALL be: ClkReg1 0x1000, ClkReg2 0xFC00, DivReg 0xC000, PowerReg 0x0000.
REQ-035 Set 0 0x08 data SHALL be 0x0082 (divide 4); set 1 0x08 data SHALL be 0x0104 (divide 8); PowerReg data SHALL be 0xFFFF in both sets.
REQ-036 The table SHALL be a sub-module reconf_rom, combinational and indexed by {set, index}.

Verification
REQ-037 SSTEP with SSTATE=0; DRP model returns DO=0xF3C7 at 0x08 -> first write is DADDR=0x08, DI=0x1082; 16 DEN pulses in total; SRDY pulses once after LOCKED.
REQ-038 SSTATE=1 with DO=0x0000 at 0x08 -> DI=0x0104; write order matches REQ-033.
REQ-039 DRDY held low after the third DEN -> ERR=1 after 255 wait cycles; PLL_RST=0; no SRDY; the next SSTEP clears ERR.
REQ-040 SSTEP pulsed while BUSY -> no restart; exactly one SRDY.
REQ-041 RST asserted during WAIT_W -> next cycle is IDLE with all outputs 0; a new SSTEP runs a full sequence.
REQ-042 LOCKED never rises -> ERR after TIMEOUT in WAIT_LOCK; BUSY=0.
